mem_req_router: RTL

- Sits directly downstream of NUM_CORES core instances; merges their per-cycle mem_req outputs onto the single memory request channel.
- Routes in-order memory responses back to the originating core's mem_rsp input.
- Each core drives mem_req unconditionally with no stall input, so the router absorbs bursts in per-core FIFOs and flags overflow.
- Round-robin arbitration among cores; one request per cycle to memory when mem_ready=1.

---
 rtl/mem_req_router_pkg.sv | 18 +
 rtl/mem_req_router_sync_fifo.sv | 48 ++++
 rtl/mem_req_router.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_req_router_pkg.sv
// Shared types and default sizing for the memory request router.
package mem_req_router_pkg;

  localparam int NUM_CORES                  = 4;
  localparam int MEM_ROUTER_FIFO_DEPTH      = 8;
  localparam int MEM_ROUTER_MAX_OUTSTANDING = 16;

  typedef struct packed {
    logic        vld;
    logic        we;
    logic [7:0]  access_id;
    logic [31:0] addr;
    logic [31:0] data;
  } request_t;

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

endpackage

// File: rtl/mem_req_router_sync_fifo.sv
// Synchronous FIFO with combinational head; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_req_router.sv
// Merges per-core requests onto one memory channel (round-robin) and routes
// in-order responses back. Define MEM_ROUTER_PERF_CNT_EN for grant/stall counters.
module mem_req_router
  import mem_req_router_pkg::*;
#(
  parameter int NUM_CORES       = mem_req_router_pkg::NUM_CORES,
  parameter int REQ_FIFO_DEPTH  = MEM_ROUTER_FIFO_DEPTH,
  parameter int MAX_OUTSTANDING = MEM_ROUTER_MAX_OUTSTANDING
) (
  input  logic                 clk,
  input  logic                 reset,
  input  request_t             core_req [NUM_CORES],
  output request_t             core_rsp [NUM_CORES],
  output request_t             mem_req,
  input  logic                 mem_ready,
  input  request_t             mem_rsp,
`ifdef MEM_ROUTER_PERF_CNT_EN
  output logic [31:0]          perf_grant_cnt [NUM_CORES],
  output logic [31:0]          perf_stall_cnt,
`endif
  output logic [NUM_CORES-1:0] req_overflow,
  output logic                 tag_full
);
  localparam int TAG_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int QCW   = $clog2(REQ_FIFO_DEPTH) + 1;
  localparam int TCW   = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_t           state, state_next;
  request_t             q_head  [NUM_CORES];
  logic [QCW-1:0]       q_count [NUM_CORES];
  logic [NUM_CORES-1:0] q_full, q_empty, q_pop, req_pend, ovf_set;
  logic [TAG_W-1:0]     rr_ptr, grant_idx, tag_head;
  logic [TCW-1:0]       tag_count;
  logic                 grant_found, grant, slot_free, tag_ok, tag_pop, tag_empty;
  int                   idx;

  // p0: per-core ingress FIFOs
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_req_q
    sync_fifo #(.WIDTH($bits(request_t)), .DEPTH(REQ_FIFO_DEPTH)) u_req_q (
      .clk       (clk),
      .reset     (reset),
      .push      (core_req[i].vld),
      .push_data (core_req[i]),
      .pop       (q_pop[i]),
      .head      (q_head[i]),
      .full      (q_full[i]),
      .empty     (q_empty[i]),
      .count     (q_count[i])
    );
    assign req_pend[i] = (q_count[i] != '0);
    assign q_pop[i]    = grant && (grant_idx == TAG_W'(i)) && !q_empty[i];
    // a pop in the same cycle frees the slot, so only a stalled full FIFO drops
    assign ovf_set[i]  = core_req[i].vld && q_full[i] && !q_pop[i];
  end

  sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (grant_idx),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  assign tag_pop   = mem_rsp.vld && !tag_empty;
  assign tag_ok    = (tag_count != TCW'(MAX_OUTSTANDING)) || tag_pop;
  assign slot_free = (state == ARB_IDLE) || mem_ready;
  assign grant     = slot_free && grant_found && tag_ok;

  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_found && req_pend[idx]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    if (grant)          state_next = ARB_HOLD;
    else if (slot_free) state_next = ARB_IDLE;
  end

  // p1: grant register toward memory, response register toward cores
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      mem_req      <= '0;
      req_overflow <= '0;
      for (int i = 0; i < NUM_CORES; i++) core_rsp[i] <= '0;
    end else begin
      state        <= state_next;
      req_overflow <= req_overflow | ovf_set;
      if (grant) begin
        mem_req     <= q_head[grant_idx];
        mem_req.vld <= 1'b1;
        rr_ptr      <= (grant_idx == TAG_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end else if (slot_free) begin
        mem_req.vld <= 1'b0;
      end
      for (int i = 0; i < NUM_CORES; i++)
        core_rsp[i] <= (tag_pop && tag_head == TAG_W'(i)) ? mem_rsp : '0;
    end
  end

`ifdef MEM_ROUTER_PERF_CNT_EN
  logic [TAG_W-1:0] cur_core;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_core       <= '0;
      perf_stall_cnt <= '0;
      for (int i = 0; i < NUM_CORES; i++) perf_grant_cnt[i] <= '0;
    end else begin
      if (grant) cur_core <= grant_idx;
      if (mem_req.vld && mem_ready && perf_grant_cnt[cur_core] != '1)
        perf_grant_cnt[cur_core] <= perf_grant_cnt[cur_core] + 1'b1;
      if (mem_req.vld && !mem_ready && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule
